rgb_rx: RTL
===========

# rgb_rx

Parallel-RGB capture stage that sits directly downstream of the `rgb` timing generator (or an external RGB panel source). Samples `de`/`hsync`/`vsync`/`r`/`g`/`b`, recovers frame geometry, and emits a registered pixel stream tagged with coordinates and start/end markers. It also flags geometry and sync violations and reports lock. It serves both as the loopback checker for `rgb` and as the front end of a video-in path.

## Interface
- `WIDTH`, 480: active pixels per line.
- `HEIGHT`, 272: active lines per frame.
- `COLOR_BITS`, 8: bits per colour channel.
- `HOR_POL_INVERTED`, 1'b1: 1 = `hsync` active low.
- `VER_POL_INVERTED`, 1'b1: 1 = `vsync` active low.
- `clk`  in  1  pixel clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `de`, `hsync`, `vsync`  in  1 each  panel control signals.
- `r`, `g`, `b`  in  COLOR_BITS each  pixel colour.
- `err_clr`  in  1  single-cycle pulse; clears the sticky error flags.
- `m_valid`  out  1  output pixel valid (no backpressure; the sink must accept every cycle).
- `m_data`  out  3*COLOR_BITS  pixel, packed {r,g,b}.
- `m_x`  out  $clog2(WIDTH)  column of the output pixel.
- `m_y`  out  $clog2(HEIGHT)  line of the output pixel.
- `m_sof`, `m_eol`  out  1 each  first pixel of frame; last pixel of line.
- `frame_done`  out  1  one-cycle pulse with `m_eol` of line HEIGHT-1.
- `locked`  out  1  geometry verified.
- `err_width`, `err_height`, `err_sync`  out  1 each  sticky error flags.
- `frame_crc`  out  16  CRC of the last completed frame.

## Operation
- Active-level sync: `hs_a = hsync ^ HOR_POL_INVERTED`, `vs_a = vsync ^ VER_POL_INVERTED`.
- **Stage 1** registers all inputs. **Stage 2** holds the output registers. Stage 1 provides one-pixel lookahead, so `m_eol` is asserted when the current pixel has `de`=1 and the next has `de`=0.
- **FSM states:**
  - `SEARCH` (reset state): all pixels are discarded. A rising edge of `vs_a` moves to `RUN`.
  - `RUN`: pixels are emitted.
- **Counters** `x` and `y` are one bit wider than needed and saturate.
  - `x` increments per `de` pixel and clears on a `de` falling edge.
  - `y` increments on each `de` falling edge and clears on a `vs_a` rising edge.
- **Emission:** a pixel is output with `m_valid`=1 only if `x<WIDTH` and `y<HEIGHT`. Excess pixels and lines are dropped.
- **Line end:** at a `de` falling edge, `x != WIDTH` sets `err_width`.
- **Frame end:** at a `vs_a` rising edge in `RUN`, `y != HEIGHT` sets `err_height`.
- **Sync violation:** `de`=1 while `hs_a` or `vs_a` is active sets `err_sync`. That pixel is still emitted.
- **Lock:**
  - `locked` sets at a `vs_a` rising edge that closes a frame with no new error during that frame.
  - `locked` clears on any error set.
- **Error clear:** `err_clr` clears all three error flags. If an error condition occurs in the same cycle as `err_clr`, the set wins.

## Timing
- Reset values: every output is 0; FSM is in `SEARCH`; counters and CRC are cleared.
- Latency: a pixel sampled at edge N appears on `m_*` after edge N+2. It is held exactly one cycle, since there is no stall.
- `m_sof`=1 on the pixel with `m_x`=0 and `m_y`=0.
- `frame_done` coincides with the final `m_eol`. `frame_crc` updates in that same cycle.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). After release, the block waits in `SEARCH`. The first frame after release can only produce `locked` at its closing vsync edge.
- A `vs_a` rising edge in the same cycle as a `de` falling edge: the line-end check runs first, then the frame-end check uses the incremented `y`.

## Configuration
- `RGB_RX_CRC_EN` defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF) over `m_data` of every emitted pixel, MSB first, 3*COLOR_BITS bits per cycle.
  - The CRC re-initialises on `m_sof`.
- Undefined: `frame_crc` is tied to 0 and no CRC logic is instantiated.

## Structure
- `rgb_pkg` holds:
  - the FSM state enum `rgb_rx_state_t`;
  - the `CRC16_POLY` and `CRC16_INIT` constants;
  - the function `crc16_next(crc, data)`.
- Sub-module `rgb_rx_crc` contains the CRC register and update logic. It is instantiated only under `RGB_RX_CRC_EN`.

## Test plan
All scenarios except the first use WIDTH=8, HEIGHT=4. The first uses `rgb` at 480x272.
- `rgb` at 480x272 driving `rgb_rx`, 3 frames -> `locked`=1 after the 2nd vsync edge; 130560 `m_valid` per frame; no error flags set.
- Reset released mid-line, then 2 clean frames -> no output before the first vsync edge; `locked` rises at the end of the first full frame.
- Line with 9 `de` cycles -> 8 pixels emitted; `err_width`=1 and `locked`=0 from the cycle after the falling edge; `err_clr` then clears the flag.
- Frame with 5 lines -> line 4 dropped; `err_height`=1 at the next vsync edge.
- `de`=1 during active `hsync` for 1 cycle -> `err_sync`=1; pixel still emitted with the correct `m_x`.
- `RGB_RX_CRC_EN` set, frame of constant 0xFCFCFC -> `frame_crc` equals the bench model's value, updated with `frame_done`; without the macro, `frame_crc`=0.

Source files
------------

// File: rtl/rgb_pkg.sv
// Shared types and CRC helpers for the rgb_rx capture stage.
// The CRC items are only referenced when RGB_RX_CRC_EN is defined.
package rgb_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    RUN    = 1'b1
  } rgb_rx_state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // CRC-16-CCITT over the low nbits of data, most significant of those bits first.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc,
                                             input logic [63:0] data,
                                             input int          nbits);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 63; i >= 0; i--) begin
      if (i < nbits) begin
        fb = c[15] ^ data[i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ CRC16_POLY;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/rgb_rx_crc.sv
// Frame CRC for rgb_rx: running CRC over emitted pixels, latched at frame end.
// Instantiated only when RGB_RX_CRC_EN is defined.
module rgb_rx_crc
  import rgb_pkg::*;
#(
  parameter int DATA_BITS = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_i,
  input  logic                 sof_i,
  input  logic                 done_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic [15:0]          crc_o
);

  logic [15:0] run_q, run_d;
  logic [15:0] crc_q;

  // Inputs are next-cycle output values, so the latched CRC lands together with frame_done.
  always_comb begin
    run_d = run_q;
    if (valid_i) run_d = crc16_next(sof_i ? CRC16_INIT : run_q, 64'(data_i), DATA_BITS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= CRC16_INIT;
      crc_q <= '0;
    end else begin
      run_q <= run_d;
      if (done_i) crc_q <= run_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/rgb_rx.sv
// rgb_rx: parallel-RGB capture with geometry recovery, sync/geometry error flags and lock.
// Optional frame CRC is built in when RGB_RX_CRC_EN is defined; otherwise frame_crc is 0.
module rgb_rx
  import rgb_pkg::*;
#(
  parameter int   WIDTH            = 480,
  parameter int   HEIGHT           = 272,
  parameter int   COLOR_BITS       = 8,
  parameter logic HOR_POL_INVERTED = 1'b1,
  parameter logic VER_POL_INVERTED = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      de,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic [COLOR_BITS-1:0]     r,
  input  logic [COLOR_BITS-1:0]     g,
  input  logic [COLOR_BITS-1:0]     b,
  input  logic                      err_clr,
  output logic                      m_valid,
  output logic [3*COLOR_BITS-1:0]   m_data,
  output logic [$clog2(WIDTH)-1:0]  m_x,
  output logic [$clog2(HEIGHT)-1:0] m_y,
  output logic                      m_sof,
  output logic                      m_eol,
  output logic                      frame_done,
  output logic                      locked,
  output logic                      err_width,
  output logic                      err_height,
  output logic                      err_sync,
  output logic [15:0]               frame_crc
);

  localparam int XW  = $clog2(WIDTH);
  localparam int YW  = $clog2(HEIGHT);
  localparam int CXW = XW + 1;
  localparam int CYW = YW + 1;
  localparam int DW  = 3 * COLOR_BITS;

  typedef struct packed {
    logic          de;
    logic          hs;
    logic          vs;
    logic [DW-1:0] data;
  } sample_t;

  sample_t        in_s, nxt_q, cur_q;
  rgb_rx_state_t  state_q;
  logic [CXW-1:0] x_q, x_d, x_after;
  logic [CYW-1:0] y_q, y_d, y_line;
  logic           frame_err_q, locked_q;
  logic           err_width_q, err_height_q, err_sync_q;
  logic           m_valid_q, m_sof_q, m_eol_q, frame_done_q;
  logic [DW-1:0]  m_data_q;
  logic [XW-1:0]  m_x_q;
  logic [YW-1:0]  m_y_q;
  logic           de_fall, vs_rise, run, emit, sof_d, eol_d, done_d;
  logic           set_w, set_h, set_s, any_set;

  assign in_s = {de, hsync ^ HOR_POL_INVERTED, vsync ^ VER_POL_INVERTED, r, g, b};

  // cur_q is the pixel being decided; nxt_q is the one-pixel lookahead for edges.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    de_fall = cur_q.de & ~nxt_q.de;
    vs_rise = ~cur_q.vs & nxt_q.vs;
    run     = (state_q == RUN);
    x_after = x_q;
    if (cur_q.de && x_q != '1) x_after = x_q + 1'b1;
    y_line  = y_q;
    if (de_fall && y_q != '1) y_line = y_q + 1'b1;
    x_d     = de_fall ? '0 : x_after;
    y_d     = vs_rise ? '0 : y_line;
    emit    = run & cur_q.de & (x_q < CXW'(WIDTH)) & (y_q < CYW'(HEIGHT));
    sof_d   = emit & (x_q == '0) & (y_q == '0);
    eol_d   = emit & de_fall;
    done_d  = eol_d & (y_q == CYW'(HEIGHT - 1));
    // Line-end check precedes frame-end, so the frame check sees the incremented y.
    set_w   = run & de_fall & (x_after != CXW'(WIDTH));
    set_h   = run & vs_rise & (y_line != CYW'(HEIGHT));
    set_s   = run & cur_q.de & (cur_q.hs | cur_q.vs);
    any_set = set_w | set_h | set_s;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= SEARCH;
      nxt_q        <= '0;
      cur_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      frame_err_q  <= 1'b0;
      locked_q     <= 1'b0;
      err_width_q  <= 1'b0;
      err_height_q <= 1'b0;
      err_sync_q   <= 1'b0;
      m_valid_q    <= 1'b0;
      m_sof_q      <= 1'b0;
      m_eol_q      <= 1'b0;
      frame_done_q <= 1'b0;
      m_data_q     <= '0;
      m_x_q        <= '0;
      m_y_q        <= '0;
    end else begin
      nxt_q <= in_s;
      cur_q <= nxt_q;
      x_q   <= x_d;
      y_q   <= y_d;
      if (vs_rise) state_q <= RUN;

      m_valid_q    <= emit;
      m_sof_q      <= sof_d;
      m_eol_q      <= eol_d;
      frame_done_q <= done_d;
      if (emit) begin
        m_data_q <= cur_q.data;
        m_x_q    <= x_q[XW-1:0];
        m_y_q    <= y_q[YW-1:0];
      end

      err_width_q  <= set_w | (err_width_q  & ~err_clr);
      err_height_q <= set_h | (err_height_q & ~err_clr);
      err_sync_q   <= set_s | (err_sync_q   & ~err_clr);

      // A frame spans vs_a rising edge to rising edge; lock needs one with no error.
      frame_err_q <= vs_rise ? 1'b0 : (frame_err_q | any_set);
      if (any_set)                               locked_q <= 1'b0;
      else if (run && vs_rise && !frame_err_q)   locked_q <= 1'b1;
    end
  end

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign m_x        = m_x_q;
  assign m_y        = m_y_q;
  assign m_sof      = m_sof_q;
  assign m_eol      = m_eol_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign err_width  = err_width_q;
  assign err_height = err_height_q;
  assign err_sync   = err_sync_q;

`ifdef RGB_RX_CRC_EN
  rgb_rx_crc #(
    .DATA_BITS(DW)
  ) u_crc (
    .clk    (clk),
    .reset  (reset),
    .valid_i(emit),
    .sof_i  (sof_d),
    .done_i (done_d),
    .data_i (cur_q.data),
    .crc_o  (frame_crc)
  );
`else
  assign frame_crc = '0;
`endif

endmodule
